// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: FSM state encoding, requant helper and
// the accumulator width check used by the classifier and conv stages.
`ifndef CNN_PKG_SV
`define CNN_PKG_SV

// Fails elaboration when the accumulator cannot hold the worst-case sum.
`define CNN_ACC_W_CHECK(ACC_W_, MIN_W_) \
  if ((ACC_W_) < (MIN_W_)) begin : g_acc_w_check \
    $error("ACC_W too narrow for worst-case accumulation"); \
  end

package cnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_FIN  = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  // Internal width for requant arithmetic; wide enough that rounding never wraps.
  localparam int RQ_W = 64;

  // Round-half-up arithmetic right shift followed by saturation to data_w bits.
  function automatic logic signed [RQ_W-1:0] requant(
    input logic signed [RQ_W-1:0] acc,
    input logic        [31:0]     shift,
    input int unsigned            data_w
  );
    logic signed [RQ_W-1:0] hi;
    logic signed [RQ_W-1:0] lo;
    logic signed [RQ_W-1:0] rnd;
    logic signed [RQ_W-1:0] res;
    hi = (64'sd1 <<< (data_w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 32'd1));
    if (shift == 32'd0) begin
      rnd = 64'sd0;
      res = acc;
    end else begin
      rnd = 64'sd1 <<< (shift - 32'd1);
      res = (acc + rnd) >>> shift;
    end
    if (res > hi) begin
      res = hi;
    end else if (res < lo) begin
      res = lo;
    end else begin
      res = res;
    end
    return res;
  endfunction

endpackage

`endif

// File: rtl/fc_requant.sv
// Combinational round-shift-saturate of a wide accumulator down to a logit.
module fc_requant
  import cnn_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 5
) (
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [DATA_W-1:0]  logit_o
);

  logic signed [RQ_W-1:0] acc_ext_s;
  logic signed [RQ_W-1:0] res_s;

  // Sign-extend the accumulator and apply the shared requant function.
  always_comb begin
    acc_ext_s = RQ_W'($signed(acc_i));
    res_s     = requant(acc_ext_s, 32'(shift_i), DATA_W);
    logit_o   = res_s[DATA_W-1:0];
  end

endmodule

// File: rtl/fc_cls_head.sv
// Fully-connected classifier head: one time-multiplexed MAC over all weights,
// per-class bias, requant to DATA_W, argmax, valid/ready result port.
module fc_cls_head
  import cnn_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int W_W     = 8,
  parameter int BIAS_W  = 16,
  parameter int ACC_W   = 24,
  parameter int NUM_IN  = 9,
  parameter int NUM_CLS = 2,
  parameter int SHIFT_W = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [NUM_IN*DATA_W-1:0]          data_i,
  input  logic [NUM_CLS*BIAS_W-1:0]         bias_i,
  input  logic [SHIFT_W-1:0]                shift_i,
  input  logic                              mode_i,
  output logic                              w_rd_o,
  output logic [$clog2(NUM_IN*NUM_CLS)-1:0] w_addr_o,
  input  logic [W_W-1:0]                    w_data_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [NUM_CLS*DATA_W-1:0]         data_o,
  output logic [$clog2(NUM_CLS)-1:0]        cls_o,
  output logic                              busy_o
);

  localparam int NC        = NUM_IN * NUM_CLS;
  localparam int AW        = $clog2(NC);
  localparam int IN_W      = $clog2(NUM_IN);
  localparam int CLS_W     = $clog2(NUM_CLS);
  localparam int MIN_ACC_W = DATA_W + W_W + $clog2(NUM_IN) + 1;
  localparam logic [IN_W-1:0]  LAST_I = IN_W'(NUM_IN - 1);
  localparam logic [CLS_W-1:0] LAST_C = CLS_W'(NUM_CLS - 1);
  localparam logic [AW-1:0]    LAST_A = AW'(NC - 1);

  `CNN_ACC_W_CHECK(ACC_W, MIN_ACC_W)

  state_e state_q, state_d;
  logic ready_q, ready_d, busy_q, busy_d, valid_q, valid_d, w_rd_q, w_rd_d;
  logic [AW-1:0]    w_addr_q, w_addr_d;
  logic [IN_W-1:0]  rd_i_q, rd_i_d, mac_i_q, mac_i_d;
  logic [CLS_W-1:0] rd_c_q, rd_c_d, mac_c_q, mac_c_d, fin_c_q, fin_c_d;
  logic             mac_v_q, mac_v_d, fin_v_q, fin_v_d, mode_q, mode_d;
  logic signed [DATA_W-1:0] x_q [NUM_IN];
  logic signed [DATA_W-1:0] x_d [NUM_IN];
  logic signed [BIAS_W-1:0] bias_q [NUM_CLS];
  logic signed [BIAS_W-1:0] bias_d [NUM_CLS];
  logic signed [DATA_W-1:0] logit_q [NUM_CLS];
  logic signed [DATA_W-1:0] logit_d [NUM_CLS];
  logic [SHIFT_W-1:0]        shift_q, shift_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  best_q, best_d;
  logic [CLS_W-1:0]          best_cls_q, best_cls_d, cls_q, cls_d;
  logic [NUM_CLS*DATA_W-1:0] data_q, data_d;

  logic                          accept_s;
  logic signed [DATA_W+W_W-1:0]  prod_s;
  logic [CLS_W-1:0]              nxt_c_s;
  logic signed [ACC_W-1:0]       acc_base_s;
  logic signed [DATA_W-1:0]      logit_s;

  fc_requant #(.ACC_W(ACC_W), .DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) u_requant (
    .acc_i   (acc_q),
    .shift_i (shift_q),
    .logit_o (logit_s)
  );

  assign accept_s = (state_q == S_IDLE) && valid_i;

  // MAC pipeline: accumulate one cycle after each read; at class end write the
  // requantised logit, update argmax and restart acc from the next class bias.
  always_comb begin
    mac_v_d = w_rd_q;
    mac_i_d = rd_i_q;
    mac_c_d = rd_c_q;
    fin_v_d = mac_v_q && (mac_i_q == LAST_I);
    fin_c_d = mac_c_q;
    prod_s  = x_q[mac_i_q] * $signed(w_data_i);
    if (fin_c_q == LAST_C) begin
      nxt_c_s = CLS_W'(0);
    end else begin
      nxt_c_s = fin_c_q + CLS_W'(1);
    end
    if (fin_v_q) begin
      acc_base_s = ACC_W'(bias_q[nxt_c_s]);
    end else begin
      acc_base_s = acc_q;
    end
    if (accept_s) begin
      acc_d = ACC_W'($signed(bias_i[BIAS_W-1:0]));
    end else if (mac_v_q) begin
      acc_d = acc_base_s + ACC_W'(prod_s);
    end else begin
      acc_d = acc_base_s;
    end
    logit_d    = logit_q;
    best_d     = best_q;
    best_cls_d = best_cls_q;
    if (fin_v_q) begin
      logit_d[fin_c_q] = logit_s;
      if ((fin_c_q == CLS_W'(0)) || (logit_s > best_q)) begin
        best_d     = logit_s;
        best_cls_d = fin_c_q;
      end else begin
        best_d     = best_q;
        best_cls_d = best_cls_q;
      end
    end else begin
      logit_d = logit_q;
    end
  end

  // Control FSM: frame capture, weight-read sequencing and output handshake.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    w_rd_d   = w_rd_q;
    w_addr_d = w_addr_q;
    rd_i_d   = rd_i_q;
    rd_c_d   = rd_c_q;
    x_d      = x_q;
    bias_d   = bias_q;
    shift_d  = shift_q;
    mode_d   = mode_q;
    data_d   = data_q;
    cls_d    = cls_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d  = S_MAC;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          w_rd_d   = 1'b1;
          w_addr_d = AW'(0);
          rd_i_d   = IN_W'(0);
          rd_c_d   = CLS_W'(0);
          for (int i = 0; i < NUM_IN; i++) x_d[i] = data_i[i*DATA_W +: DATA_W];
          for (int c = 0; c < NUM_CLS; c++) bias_d[c] = bias_i[c*BIAS_W +: BIAS_W];
          shift_d  = shift_i;
          mode_d   = mode_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        if (w_rd_q) begin
          if (w_addr_q == LAST_A) begin
            w_rd_d = 1'b0;
          end else begin
            w_addr_d = w_addr_q + AW'(1);
            if (rd_i_q == LAST_I) begin
              rd_i_d = IN_W'(0);
              rd_c_d = rd_c_q + CLS_W'(1);
            end else begin
              rd_i_d = rd_i_q + IN_W'(1);
            end
          end
        end else begin
          w_rd_d = 1'b0;
        end
        if (mac_v_q && (mac_i_q == LAST_I) && (mac_c_q == LAST_C)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_MAC;
        end
      end
      S_FIN: begin
        state_d = S_OUT;
        valid_d = 1'b1;
        cls_d   = best_cls_d;
        for (int c = 0; c < NUM_CLS; c++) begin
          data_d[c*DATA_W +: DATA_W] = mode_q ? {DATA_W{1'b0}} : logit_d[c];
        end
      end
      S_OUT: begin
        if (ready_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        w_rd_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  ready_q <= 1'b1;  busy_q <= 1'b0;  valid_q <= 1'b0;
      w_rd_q <= 1'b0;  w_addr_q <= AW'(0);  rd_i_q <= IN_W'(0);  rd_c_q <= CLS_W'(0);
      mac_v_q <= 1'b0;  mac_i_q <= IN_W'(0);  mac_c_q <= CLS_W'(0);
      fin_v_q <= 1'b0;  fin_c_q <= CLS_W'(0);
      for (int i = 0; i < NUM_IN; i++) x_q[i] <= {DATA_W{1'b0}};
      for (int c = 0; c < NUM_CLS; c++) begin
        bias_q[c]  <= {BIAS_W{1'b0}};
        logit_q[c] <= {DATA_W{1'b0}};
      end
      shift_q <= {SHIFT_W{1'b0}};  mode_q <= 1'b0;  acc_q <= {ACC_W{1'b0}};
      best_q <= {DATA_W{1'b0}};  best_cls_q <= CLS_W'(0);
      data_q <= {(NUM_CLS*DATA_W){1'b0}};  cls_q <= CLS_W'(0);
    end else begin
      state_q <= state_d;  ready_q <= ready_d;  busy_q <= busy_d;  valid_q <= valid_d;
      w_rd_q <= w_rd_d;  w_addr_q <= w_addr_d;  rd_i_q <= rd_i_d;  rd_c_q <= rd_c_d;
      mac_v_q <= mac_v_d;  mac_i_q <= mac_i_d;  mac_c_q <= mac_c_d;
      fin_v_q <= fin_v_d;  fin_c_q <= fin_c_d;
      x_q <= x_d;  bias_q <= bias_d;  logit_q <= logit_d;
      shift_q <= shift_d;  mode_q <= mode_d;  acc_q <= acc_d;
      best_q <= best_d;  best_cls_q <= best_cls_d;
      data_q <= data_d;  cls_q <= cls_d;
    end
  end

  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign w_rd_o   = w_rd_q;
  assign w_addr_o = w_addr_q;
  assign data_o   = data_q;
  assign cls_o    = cls_q;

endmodule

// File: tb/tb_fc_cls_head.sv
// Directed bench for fc_cls_head: default 9x2 instance plus a 4x5 instance.
module tb_fc_cls_head;

  typedef struct packed {
    logic [79:0] data;
    logic [7:0]  cls;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance (9 inputs, 2 classes)
  logic        a_valid_i = 1'b0, a_ready_o, a_mode_i = 1'b0, a_w_rd, a_valid_o, a_ready_i = 1'b0, a_busy;
  logic [71:0] a_data_i = '0;
  logic [31:0] a_bias_i = '0;
  logic [4:0]  a_shift_i = '0, a_w_addr;
  logic [7:0]  a_w_data = '0;
  logic [15:0] a_data_o;
  logic [0:0]  a_cls_o;

  // second instance (4 inputs, 5 classes)
  logic        b_valid_i = 1'b0, b_ready_o, b_mode_i = 1'b0, b_w_rd, b_valid_o, b_ready_i = 1'b0, b_busy;
  logic [31:0] b_data_i = '0;
  logic [79:0] b_bias_i = '0;
  logic [4:0]  b_shift_i = '0, b_w_addr;
  logic [7:0]  b_w_data = '0;
  logic [39:0] b_data_o;
  logic [2:0]  b_cls_o;

  fc_cls_head u_a (
    .clk(clk), .rst(rst), .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i),
    .bias_i(a_bias_i), .shift_i(a_shift_i), .mode_i(a_mode_i), .w_rd_o(a_w_rd),
    .w_addr_o(a_w_addr), .w_data_i(a_w_data), .valid_o(a_valid_o), .ready_i(a_ready_i),
    .data_o(a_data_o), .cls_o(a_cls_o), .busy_o(a_busy)
  );

  fc_cls_head #(.NUM_IN(4), .NUM_CLS(5)) u_b (
    .clk(clk), .rst(rst), .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .bias_i(b_bias_i), .shift_i(b_shift_i), .mode_i(b_mode_i), .w_rd_o(b_w_rd),
    .w_addr_o(b_w_addr), .w_data_i(b_w_data), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .data_o(b_data_o), .cls_o(b_cls_o), .busy_o(b_busy)
  );

  logic signed [7:0]  mx [16];
  logic signed [7:0]  mw [32];
  logic signed [15:0] mb [8];
  exp_t sb [$];
  int a_log [$];
  int b_log [$];
  int a_hs = 0;
  int n_cmp = 0;
  int n_err = 0;

  // Weight SRAM model (one-cycle read latency), read-address logging, handshake count.
  always @(posedge clk) begin
    if (a_w_rd) begin a_w_data <= mw[a_w_addr]; a_log.push_back(int'(a_w_addr)); end
    if (b_w_rd) begin b_w_data <= mw[b_w_addr]; b_log.push_back(int'(b_w_addr)); end
    if (a_valid_o && a_ready_i) a_hs <= a_hs + 1;
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint rq(input longint acc, input int sh);
    longint r;
    if (sh == 0) r = acc;
    else r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic exp_t model(input int ni, input int ncls, input int sh, input bit md);
    exp_t e;
    longint acc, r, best;
    int bc;
    e = '0; best = 0; bc = 0;
    for (int c = 0; c < ncls; c++) begin
      acc = longint'(mb[c]);
      for (int i = 0; i < ni; i++) acc += longint'(mx[i]) * longint'(mw[c*ni+i]);
      r = rq(acc, sh);
      if (c == 0 || r > best) begin best = r; bc = c; end
      if (!md) e.data[c*8 +: 8] = 8'(r);
    end
    e.cls = 8'(bc);
    return e;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, ".ready"}, 80'(a_ready_o), 80'(1));
    check({tag, ".valid"}, 80'(a_valid_o), 80'(0));
    check({tag, ".wrd"},   80'(a_w_rd), 80'(0));
    check({tag, ".waddr"}, 80'(a_w_addr), 80'(0));
    check({tag, ".data"},  80'(a_data_o), 80'(0));
    check({tag, ".cls"},   80'(a_cls_o), 80'(0));
    check({tag, ".busy"},  80'(a_busy), 80'(0));
  endtask

  task automatic check_addr(input string tag, input bit use_b, input int n);
    int bad;
    bad = 0;
    if (use_b) begin
      if (b_log.size() != n) bad = 1000 + b_log.size();
      else for (int k = 0; k < n; k++) if (b_log[k] != k) bad++;
    end else begin
      if (a_log.size() != n) bad = 1000 + a_log.size();
      else for (int k = 0; k < n; k++) if (a_log[k] != k) bad++;
    end
    check({tag, ".addr_seq"}, 80'(bad), 80'(0));
  endtask

  task automatic drive_a(input int sh, input bit md);
    for (int i = 0; i < 9; i++) a_data_i[i*8 +: 8] = mx[i];
    for (int c = 0; c < 2; c++) a_bias_i[c*16 +: 16] = mb[c];
    a_shift_i = 5'(sh);
    a_mode_i  = md;
    a_valid_i = 1'b1;
  endtask

  task automatic frame_a(input string tag, input int sh, input bit md, input int hold, input bit pulse);
    exp_t e;
    int lat;
    sb.push_back(model(9, 2, sh, md));
    @(negedge clk);
    a_log.delete();
    drive_a(sh, md);
    check({tag, ".ready_in"}, 80'(a_ready_o), 80'(1));
    @(negedge clk);
    a_valid_i = 1'b0;
    lat = 1;
    while (a_valid_o !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    check({tag, ".latency"}, 80'(lat), 80'(21));
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      check({tag, ".hold_data"}, 80'(a_data_o), e.data);
      check({tag, ".hold_ready"}, 80'({a_ready_o, a_w_rd, a_valid_o}), 80'(3'b001));
      a_valid_i = pulse && (h == 3);
      @(negedge clk);
    end
    a_valid_i = 1'b0;
    check({tag, ".data"}, 80'(a_data_o), e.data);
    check({tag, ".cls"}, 80'(a_cls_o), 80'(e.cls));
    a_ready_i = 1'b1;
    @(negedge clk);
    a_ready_i = 1'b0;
    check({tag, ".post_hs"}, 80'({a_valid_o, a_ready_o, a_busy}), 80'(3'b010));
    check_addr(tag, 1'b0, 18);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int lat;
    int hs0;
    // reset state
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // test 1: x=1, w0=2, w1=-1 -> {-9,18}, cls 0
    for (int i = 0; i < 9; i++) begin mx[i] = 8'sd1; mw[i] = 8'sd2; mw[9+i] = -8'sd1; end
    mb[0] = 16'sd0; mb[1] = 16'sd0;
    frame_a("t1", 0, 1'b0, 0, 1'b0);

    // test 2: saturation both ways, argmax on saturated values
    for (int i = 0; i < 9; i++) begin mx[i] = 8'sd127; mw[i] = 8'sd127; mw[9+i] = -8'sd127; end
    frame_a("t2a", 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin mw[i] = -8'sd127; mw[9+i] = 8'sd127; end
    frame_a("t2b", 0, 1'b0, 0, 1'b0);

    // test 3: rounding with shift 4 (weights zero, acc = bias)
    for (int k = 0; k < 18; k++) mw[k] = 8'sd0;
    mb[0] = 16'sd24; mb[1] = -16'sd24;
    frame_a("t3a", 4, 1'b0, 0, 1'b0);
    mb[0] = 16'sd8;  mb[1] = 16'sd24;
    frame_a("t3b", 4, 1'b0, 0, 1'b0);

    // test 4: tie keeps lowest index; class-only mode zeroes data
    for (int i = 0; i < 9; i++) begin mx[i] = 8'(i + 1); mw[i] = 8'sd1; mw[9+i] = 8'sd1; end
    mb[0] = 16'sd0; mb[1] = 16'sd0;
    frame_a("t4a", 0, 1'b0, 0, 1'b0);
    frame_a("t4b", 0, 1'b1, 0, 1'b0);

    // test 5: back-pressure for 10 cycles with a stray valid pulse
    for (int i = 0; i < 9; i++) begin mx[i] = 8'sd1; mw[i] = 8'sd2; mw[9+i] = -8'sd1; end
    hs0 = a_hs;
    frame_a("t5", 0, 1'b0, 10, 1'b1);
    repeat (3) @(negedge clk);
    check("t5.one_hs", 80'(a_hs - hs0), 80'(1));
    check("t5.idle", 80'({a_valid_o, a_busy, a_ready_o}), 80'(3'b001));
    frame_a("t5n", 2, 1'b0, 0, 1'b0);

    // test 6: reset at MAC cycle 8, then a clean frame
    @(negedge clk);
    drive_a(0, 1'b0);
    @(negedge clk);
    a_valid_i = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("t6.rst");
    @(negedge clk);
    rst = 1'b0;
    frame_a("t6", 0, 1'b0, 0, 1'b0);

    // 4-input / 5-class instance: address order and latency
    for (int i = 0; i < 4; i++) mx[i] = 8'((i * 5) - 7);
    for (int k = 0; k < 20; k++) mw[k] = 8'(((k * 7) % 11) - 5);
    for (int c = 0; c < 5; c++) mb[c] = 16'((c * 10) - 20);
    sb.push_back(model(4, 5, 2, 1'b0));
    @(negedge clk);
    b_log.delete();
    for (int i = 0; i < 4; i++) b_data_i[i*8 +: 8] = mx[i];
    for (int c = 0; c < 5; c++) b_bias_i[c*16 +: 16] = mb[c];
    b_shift_i = 5'd2;
    b_mode_i  = 1'b0;
    b_valid_i = 1'b1;
    @(negedge clk);
    b_valid_i = 1'b0;
    lat = 1;
    while (b_valid_o !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    check("b.latency", 80'(lat), 80'(23));
    e = sb.pop_front();
    check("b.data", 80'(b_data_o), e.data);
    check("b.cls", 80'(b_cls_o), 80'(e.cls));
    b_ready_i = 1'b1;
    @(negedge clk);
    b_ready_i = 1'b0;
    check("b.post_hs", 80'({b_valid_o, b_ready_o, b_busy}), 80'(3'b010));
    check_addr("b", 1'b1, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
